// File: rtl/cp0_pkg.sv
// Shared CP0 trap-controller definitions: exception codes, Status/CP0 indices,
// instruction field constants and the trap sequencer state type.
package cp0_pkg;

    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    localparam int ST_IE           = 0;
    localparam int ST_MASK_SYSCALL = 1;
    localparam int ST_MASK_BREAK   = 2;
    localparam int ST_MASK_TEQ     = 3;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_BREAK   = 6'h0D;
    localparam logic [5:0] FN_TEQ     = 6'h34;
    localparam logic [4:0] RS_MF      = 5'h00;
    localparam logic [4:0] RS_MT      = 5'h04;
    localparam logic [31:0] ERET_WORD = 32'h42000018;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_VECTOR,
        ST_RETURN,
        ST_RESUME
    } trap_state_t;

    // A trap is taken only with global IE set and the per-cause mask bit set.
    function automatic logic trap_enabled(input logic [31:0] status, input logic [4:0] code);
        logic mask;
        case (code)
            EXC_SYSCALL: mask = status[ST_MASK_SYSCALL];
            EXC_BREAK:   mask = status[ST_MASK_BREAK];
            EXC_TEQ:     mask = status[ST_MASK_TEQ];
            default:     mask = 1'b0;
        endcase
        return status[ST_IE] && mask;
    endfunction

endpackage

// File: rtl/cp0_trap_decode.sv
// Combinational classifier for trap, ERET and CP0 move instructions in execute.
// Zero latency; no flow control.
module cp0_trap_decode
    import cp0_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        is_trap,
    output logic [4:0]  exc_code,
    output logic        is_eret,
    output logic        is_mfc0,
    output logic        is_mtc0
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign funct = instr[5:0];

    always_comb begin
        is_trap  = 1'b0;
        exc_code = '0;
        if (op == OP_SPECIAL) begin
            case (funct)
                FN_SYSCALL: begin
                    is_trap  = 1'b1;
                    exc_code = EXC_SYSCALL;
                end
                FN_BREAK: begin
                    is_trap  = 1'b1;
                    exc_code = EXC_BREAK;
                end
                FN_TEQ: begin
                    // TEQ with unequal operands is an ordinary no-op
                    is_trap  = (rs_data == rt_data);
                    exc_code = EXC_TEQ;
                end
                default: ;
            endcase
        end
    end

    assign is_eret = (instr == ERET_WORD);
    assign is_mfc0 = (op == OP_COP0) && (rs == RS_MF);
    assign is_mtc0 = (op == OP_COP0) && (rs == RS_MT);

endmodule

// File: rtl/cp0_trap_ctrl.sv
// Trap/ERET sequencer and CP0 write-strobe driver between execute and CP0.
// Trap/ERET: CP0 written at end of N+1, redirect in N+2; MFC0/MTC0 combinational.
module cp0_trap_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h00400004,
    parameter int          EXC_SHIFT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] status_in,
    input  logic [31:0] epc_in,
    output logic        mfc0,
    output logic        mtc0,
    output logic [4:0]  cp0_addr,
    output logic [31:0] cp0_wdata,
    output logic        wsta,
    output logic        wcau,
    output logic        wepc,
    output logic        exception,
    output logic        eret,
    output logic [31:0] cause,
    output logic [31:0] epc_pc,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc
);

    trap_state_t state, state_nxt;
    logic        is_trap, is_eret, is_mfc0, is_mtc0;
    logic [4:0]  exc_code;
    logic        trap_take;

    cp0_trap_decode u_decode (
        .instr    (instr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .is_trap  (is_trap),
        .exc_code (exc_code),
        .is_eret  (is_eret),
        .is_mfc0  (is_mfc0),
        .is_mtc0  (is_mtc0)
    );

    assign cp0_addr  = instr[15:11];
    assign cp0_wdata = rt_data;

    // Outputs are gated by rst so an abandoned sequence never strobes CP0.
    always_comb begin
        state_nxt   = state;
        trap_take   = 1'b0;
        mfc0        = 1'b0;
        mtc0        = 1'b0;
        wsta        = 1'b0;
        wcau        = 1'b0;
        wepc        = 1'b0;
        exception   = 1'b0;
        eret        = 1'b0;
        stall       = 1'b0;
        pc_redirect = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        if (is_trap) begin
                            if (trap_enabled(status_in, exc_code)) begin
                                trap_take = 1'b1;
                                stall     = 1'b1;
                                state_nxt = ST_ENTRY;
                            end
                        end else if (is_eret) begin
                            stall     = 1'b1;
                            state_nxt = ST_RETURN;
                        end else if (is_mtc0) begin
                            mtc0 = 1'b1;
                            wsta = (cp0_addr == CP0_STATUS);
                            wcau = (cp0_addr == CP0_CAUSE);
                            wepc = (cp0_addr == CP0_EPC);
                        end else if (is_mfc0) begin
                            mfc0 = 1'b1;
                        end
                    end
                end
                ST_ENTRY: begin
                    exception = 1'b1;
                    wsta      = 1'b1;
                    wcau      = 1'b1;
                    wepc      = 1'b1;
                    stall     = 1'b1;
                    state_nxt = ST_VECTOR;
                end
                ST_VECTOR: begin
                    pc_redirect = 1'b1;
                    stall       = 1'b1;
                    state_nxt   = ST_IDLE;
                end
                ST_RETURN: begin
                    eret      = 1'b1;
                    wsta      = 1'b1;
                    wcau      = 1'b1;
                    stall     = 1'b1;
                    state_nxt = ST_RESUME;
                end
                ST_RESUME: begin
                    pc_redirect = 1'b1;
                    stall       = 1'b1;
                    state_nxt   = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cause       <= '0;
            epc_pc      <= '0;
            redirect_pc <= '0;
        end else begin
            state <= state_nxt;
            if (trap_take) begin
                epc_pc <= pc;
                cause  <= 32'(exc_code) << EXC_SHIFT;
            end
            // redirect_pc is loaded one cycle ahead of its redirect pulse
            if (state == ST_ENTRY)
                redirect_pc <= HANDLER_ADDR;
            else if (state == ST_RETURN)
                redirect_pc <= epc_in;
        end
    end

endmodule

// File: tb/tb_cp0_trap_ctrl.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_cp0_trap_ctrl;

    localparam logic [31:0] HANDLER  = 32'h00400004;
    localparam logic [31:0] I_SYS    = 32'h0000000C;
    localparam logic [31:0] I_BRK    = 32'h0000000D;
    localparam logic [31:0] I_TEQ    = 32'h01090034;
    localparam logic [31:0] I_ERET   = 32'h42000018;
    localparam logic [31:0] I_MTC13  = 32'h40886800;
    localparam logic [31:0] I_MTC9   = 32'h40884800;

    localparam logic [8:0] B_MFC0  = 9'h100;
    localparam logic [8:0] B_MTC0  = 9'h080;
    localparam logic [8:0] B_WSTA  = 9'h040;
    localparam logic [8:0] B_WCAU  = 9'h020;
    localparam logic [8:0] B_WEPC  = 9'h010;
    localparam logic [8:0] B_EXC   = 9'h008;
    localparam logic [8:0] B_ERET  = 9'h004;
    localparam logic [8:0] B_STALL = 9'h002;
    localparam logic [8:0] B_REDIR = 9'h001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0, pc = '0, rs_data = '0, rt_data = '0;
    logic [31:0] status_in = '0, epc_in = '0;
    logic        mfc0, mtc0, wsta, wcau, wepc, exception, eret, stall, pc_redirect;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata, cause, epc_pc, redirect_pc;
    logic [8:0]  dut_flags;

    always #5 clk = ~clk;

    cp0_trap_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .pc(pc),
        .rs_data(rs_data), .rt_data(rt_data), .status_in(status_in), .epc_in(epc_in),
        .mfc0(mfc0), .mtc0(mtc0), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .wsta(wsta), .wcau(wcau), .wepc(wepc), .exception(exception), .eret(eret),
        .cause(cause), .epc_pc(epc_pc), .stall(stall), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc)
    );

    assign dut_flags = {mfc0, mtc0, wsta, wcau, wepc, exception, eret, stall, pc_redirect};

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Reference model: a taken trap or ERET schedules its future output cycles in a queue.
    typedef struct {
        logic [8:0] f;
        int         ld;   // 0: keep redirect, 1: load handler, 2: load epc_in
    } step_t;

    step_t       q[$];
    logic [31:0] m_cause = '0, m_epc = '0, m_redir = '0;

    initial begin
        step_t       s;
        logic [8:0]  exp_f;
        logic [31:0] nc, ne, nr;
        logic [5:0]  op, fn;
        logic [4:0]  rsf, rdf;
        int          code;
        logic        en;
        forever begin
            @(negedge clk);
            exp_f = '0;
            nc = m_cause; ne = m_epc; nr = m_redir;
            if (rst) begin
                q.delete();
                nc = '0; ne = '0; nr = '0;
            end else if (q.size() != 0) begin
                s = q.pop_front();
                exp_f = s.f;
                if (s.ld == 1) nr = HANDLER;
                else if (s.ld == 2) nr = epc_in;
            end else if (instr_valid) begin
                op = instr[31:26]; rsf = instr[25:21]; rdf = instr[15:11]; fn = instr[5:0];
                code = 0;
                if (op == 6'h00 && fn == 6'h0C) code = 8;
                if (op == 6'h00 && fn == 6'h0D) code = 9;
                if (op == 6'h00 && fn == 6'h34 && rs_data == rt_data) code = 13;
                en = status_in[0] && ((code == 8 && status_in[1]) ||
                                      (code == 9 && status_in[2]) ||
                                      (code == 13 && status_in[3]));
                if (code != 0) begin
                    if (en) begin
                        exp_f = B_STALL;
                        q.push_back('{B_EXC | B_WSTA | B_WCAU | B_WEPC | B_STALL, 1});
                        q.push_back('{B_REDIR | B_STALL, 0});
                        nc = code * 4;
                        ne = pc;
                    end
                end else if (instr == I_ERET) begin
                    exp_f = B_STALL;
                    q.push_back('{B_ERET | B_WSTA | B_WCAU | B_STALL, 2});
                    q.push_back('{B_REDIR | B_STALL, 0});
                end else if (op == 6'h10 && rsf == 5'd4) begin
                    exp_f = B_MTC0;
                    if (rdf == 5'd12) exp_f = exp_f | B_WSTA;
                    if (rdf == 5'd13) exp_f = exp_f | B_WCAU;
                    if (rdf == 5'd14) exp_f = exp_f | B_WEPC;
                end else if (op == 6'h10 && rsf == 5'd0) begin
                    exp_f = B_MFC0;
                end
            end
            check("model_flags", {23'b0, dut_flags}, {23'b0, exp_f});
            check("model_cause", cause, m_cause);
            check("model_epc_pc", epc_pc, m_epc);
            check("model_redirect_pc", redirect_pc, m_redir);
            check("model_cp0_addr", {27'b0, cp0_addr}, {27'b0, instr[15:11]});
            check("model_cp0_wdata", cp0_wdata, rt_data);
            m_cause = nc; m_epc = ne; m_redir = nr;
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] st, input logic [31:0] ep);
        @(posedge clk);
        #1;
        instr_valid = v; instr = ins; pc = p; rs_data = a; rt_data = b;
        status_in = st; epc_in = ep;
    endtask

    task automatic idle_cyc();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, status_in, epc_in);
    endtask

    initial begin
        int          stall_cnt;
        logic [31:0] ins, a, b, st;
        int          k;

        idle_cyc();
        idle_cyc();
        rst = 1'b0;
        @(negedge clk);
        check_b("reset_stall", stall, 1'b0);
        check("reset_cause", cause, 32'h0);
        check("reset_redirect_pc", redirect_pc, 32'h0);

        drive(1'b1, I_SYS, 32'h00400100, 0, 0, 32'h0F, 0);
        @(negedge clk);
        check_b("syscall_idle_stall", stall, 1'b1);
        check_b("syscall_idle_no_exc", exception, 1'b0);
        idle_cyc();
        @(negedge clk);
        check_b("syscall_entry_exception", exception, 1'b1);
        check_b("syscall_entry_wepc", wepc, 1'b1);
        check("syscall_cause", cause, 32'h20);
        check("syscall_epc_pc", epc_pc, 32'h00400100);
        idle_cyc();
        @(negedge clk);
        check_b("syscall_vector_redirect", pc_redirect, 1'b1);
        check("syscall_vector_pc", redirect_pc, 32'h00400004);
        idle_cyc();
        @(negedge clk);
        check_b("syscall_done_stall", stall, 1'b0);

        drive(1'b1, I_TEQ, 32'h00400200, 5, 5, 32'h0F, 0);
        idle_cyc();
        @(negedge clk);
        check("teq_eq_cause", cause, 32'h34);
        check_b("teq_eq_exception", exception, 1'b1);
        idle_cyc();
        @(negedge clk);
        check_b("teq_eq_redirect", pc_redirect, 1'b1);
        drive(1'b1, I_TEQ, 32'h00400210, 5, 6, 32'h0F, 0);
        @(negedge clk);
        check("teq_ne_nop", {23'b0, dut_flags}, 32'h0);

        drive(1'b1, I_BRK, 32'h00400220, 0, 0, 32'h0B, 0);
        @(negedge clk);
        check("break_masked_nop", {23'b0, dut_flags}, 32'h0);
        drive(1'b1, I_SYS, 32'h00400224, 0, 0, 32'h0E, 0);
        @(negedge clk);
        check("syscall_ie0_nop", {23'b0, dut_flags}, 32'h0);

        stall_cnt = 0;
        drive(1'b1, I_ERET, 32'h00400228, 0, 0, 32'h0F, 32'h00400120);
        @(negedge clk);
        stall_cnt += int'(stall);
        idle_cyc();
        @(negedge clk);
        stall_cnt += int'(stall);
        check("eret_return_flags", {23'b0, dut_flags}, {23'b0, B_ERET | B_WSTA | B_WCAU | B_STALL});
        idle_cyc();
        @(negedge clk);
        stall_cnt += int'(stall);
        check_b("eret_resume_redirect", pc_redirect, 1'b1);
        check("eret_resume_pc", redirect_pc, 32'h00400120);
        idle_cyc();
        @(negedge clk);
        stall_cnt += int'(stall);
        check("eret_stall_cycles", stall_cnt, 3);

        drive(1'b1, I_MTC13, 32'h00400300, 0, 32'hDEAD, 32'h0F, 0);
        @(negedge clk);
        check("mtc0_cause_flags", {23'b0, dut_flags}, {23'b0, B_MTC0 | B_WCAU});
        check("mtc0_wdata", cp0_wdata, 32'hDEAD);
        drive(1'b1, I_MTC9, 32'h00400304, 0, 32'hBEEF, 32'h0F, 0);
        @(negedge clk);
        check("mtc0_reg9_flags", {23'b0, dut_flags}, {23'b0, B_MTC0});

        drive(1'b1, I_SYS, 32'h00400400, 0, 0, 32'h0F, 0);
        idle_cyc();
        idle_cyc();
        rst = 1'b1;
        idle_cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_vector_flags", {23'b0, dut_flags}, 32'h0);
        check("rst_vector_cause", cause, 32'h0);
        check("rst_vector_epc_pc", epc_pc, 32'h0);
        check("rst_vector_redirect_pc", redirect_pc, 32'h0);
        drive(1'b1, I_SYS, 32'h00400500, 0, 0, 32'h0F, 0);
        idle_cyc();
        @(negedge clk);
        check_b("restart_exception", exception, 1'b1);
        check("restart_epc_pc", epc_pc, 32'h00400500);
        idle_cyc();
        idle_cyc();

        for (int i = 0; i < 4000; i++) begin
            k = $urandom_range(0, 9);
            b = $urandom;
            a = ($urandom_range(0, 1) != 0) ? b : $urandom;
            case (k)
                0: ins = {6'h00, 20'($urandom), 6'h0C};
                1: ins = {6'h00, 20'($urandom), 6'h0D};
                2: ins = {6'h00, 20'($urandom), 6'h34};
                3: ins = I_ERET;
                4: ins = {6'h10, 5'h00, 21'($urandom)};
                5, 6: begin
                    ins = {6'h10, 5'h04, 5'($urandom), 5'($urandom_range(9, 15)), 11'h0};
                end
                7: ins = $urandom;
                default: ins = {6'h00, 20'($urandom), 6'h20};
            endcase
            st = $urandom;
            drive(($urandom_range(0, 3) != 0), ins, $urandom, a, b, st, $urandom);
            rst = ($urandom_range(0, 59) == 0);
        end
        rst = 1'b0;
        idle_cyc();
        idle_cyc();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
